// File: rtl/sc_scoredisplay_pkg.sv
// Shared types and constants for the score display: converter states,
// active-low seven-segment patterns and double-dabble helpers.
package sc_scoredisplay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    localparam int DD_ITERS = 6;

    // Active-low patterns written as {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction applied to each BCD nibble before every shift.
    function automatic logic [7:0] dd_adjust(input logic [7:0] bcd);
        logic [7:0] r;
        r = bcd;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        return r;
    endfunction

endpackage

// File: rtl/sc_bin2bcd.sv
// Sequential double-dabble converter: 6-bit binary to two BCD digits,
// one shift step per clock (IDLE -> SHIFT x6 -> LOAD).
module sc_bin2bcd
    import sc_scoredisplay_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcd
);

    conv_state_t state, state_next;
    logic [5:0]  operand;
    logic [2:0]  iter;
    logic [7:0]  scratch;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            operand <= '0;
            iter    <= '0;
            scratch <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        operand <= bin;
                        scratch <= '0;
                        iter    <= '0;
                    end
                end
                SHIFT: begin
                    {scratch, operand} <= {dd_adjust(scratch), operand} << 1;
                    iter               <= iter + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: state_next gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (iter == 3'(DD_ITERS - 1)) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign done = (state == LOAD);
    assign bcd  = scratch;

endmodule

// File: rtl/sc_scoredisplay.sv
// Score display driver: BCD conversion, 2-digit multiplexed active-low display
// with leading-zero blanking and game-over blink. High score: SC_SCOREDISPLAY_HISCORE_EN.
module sc_scoredisplay
    import sc_scoredisplay_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 256
) (
    input  logic       SC_SCOREDISPLAY_CLOCK_50,
    input  logic       SC_SCOREDISPLAY_RESET_InHigh,
    input  logic [5:0] SC_SCOREDISPLAY_Score_InBus,
    input  logic       SC_SCOREDISPLAY_Lost_inLow,
    output logic [6:0] SC_SCOREDISPLAY_Segments_OutBus,
    output logic [1:0] SC_SCOREDISPLAY_DigitSel_OutBus,
    output logic       SC_SCOREDISPLAY_Busy_Out,
    output logic [5:0] SC_SCOREDISPLAY_HiScore_OutBus
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic          clk, rst, lost_n;
    logic [5:0]    score, score_last;
    logic          accept, conv_busy, conv_done;
    logic [7:0]    conv_bcd;
    logic [3:0]    tens, units;
    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic          slot, blink_phase;
    logic          wrap, blink_wrap, slot_next, phase_next;
    logic [6:0]    seg_next;
    logic [1:0]    sel_next;

    assign clk    = SC_SCOREDISPLAY_CLOCK_50;
    assign rst    = SC_SCOREDISPLAY_RESET_InHigh;
    assign score  = SC_SCOREDISPLAY_Score_InBus;
    assign lost_n = SC_SCOREDISPLAY_Lost_inLow;

    // Only the latest score is compared, so changes during a conversion collapse into one.
    assign accept = (score != score_last) && !conv_busy;

    sc_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .bin   (score),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        wrap       = (refresh_cnt == RW'(REFRESH_DIV - 1));
        blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));
        slot_next  = ~slot;
        phase_next = blink_phase ^ blink_wrap;
        seg_next   = slot_next ? ((tens == 4'd0) ? SEG_BLANK : seg_encode(tens))
                               : seg_encode(units);
        sel_next   = (!lost_n && phase_next) ? 2'b11
                   : (slot_next ? 2'b01 : 2'b10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_last  <= '0;
            tens        <= '0;
            units       <= '0;
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            slot        <= 1'b0;
            SC_SCOREDISPLAY_Segments_OutBus <= SEG_0;
            SC_SCOREDISPLAY_DigitSel_OutBus <= 2'b10;
        end else begin
            if (accept) score_last <= score;
            if (conv_done) begin
                tens  <= conv_bcd[7:4];
                units <= conv_bcd[3:0];
            end
            refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
            if (lost_n) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (wrap) begin
                blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
                blink_phase <= phase_next;
            end
            // Segments and enables move together at the slot boundary.
            if (wrap) begin
                slot                            <= slot_next;
                SC_SCOREDISPLAY_Segments_OutBus <= seg_next;
                SC_SCOREDISPLAY_DigitSel_OutBus <= sel_next;
            end
        end
    end

    assign SC_SCOREDISPLAY_Busy_Out = conv_busy;

`ifdef SC_SCOREDISPLAY_HISCORE_EN
    logic       lost_q;
    logic [5:0] hi_score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_q   <= 1'b1;
            hi_score <= '0;
        end else begin
            lost_q <= lost_n;
            if (lost_q && !lost_n && (score > hi_score)) hi_score <= score;
        end
    end

    assign SC_SCOREDISPLAY_HiScore_OutBus = hi_score;
`else
    assign SC_SCOREDISPLAY_HiScore_OutBus = 6'd0;
`endif

endmodule

// File: tb/tb_sc_scoredisplay.sv
// Self-checking bench for sc_scoredisplay: directed cases plus random scores
// compared against decimal/segment expectations computed in the bench.
`timescale 1ns/1ps
module tb_sc_scoredisplay;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 2;
    localparam int OBS         = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] score;
    logic       lost_n;
    logic [6:0] seg;
    logic [1:0] dsel;
    logic       busy;
    logic [5:0] hi;

    int n_checks = 0;
    int n_pass   = 0;
    int hi_model = 0;
    bit dark [OBS];

    sc_scoredisplay #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .SC_SCOREDISPLAY_CLOCK_50        (clk),
        .SC_SCOREDISPLAY_RESET_InHigh    (rst),
        .SC_SCOREDISPLAY_Score_InBus     (score),
        .SC_SCOREDISPLAY_Lost_inLow      (lost_n),
        .SC_SCOREDISPLAY_Segments_OutBus (seg),
        .SC_SCOREDISPLAY_DigitSel_OutBus (dsel),
        .SC_SCOREDISPLAY_Busy_Out        (busy),
        .SC_SCOREDISPLAY_HiScore_OutBus  (hi)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Segment lit lists: 0=abcdef 1=bc 2=abdeg 3=abcdg 4=bcfg 5=acdfg
    // 6=acdefg 7=abc 8=all 9=abcdfg; bit set = segment dark.
    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called just after a score change at a negedge; returns number of busy-high samples.
    task automatic run_conversion(output int busy_len);
        int guard;
        busy_len = 0;
        guard    = 0;
        while (busy !== 1'b1 && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        while (busy === 1'b1 && busy_len < 30) begin
            busy_len++;
            @(negedge clk);
        end
    endtask

    task automatic check_display(input string tag, input int value);
        logic [6:0] seen_u, seen_t;
        seen_u = 'x;
        seen_t = 'x;
        repeat (2 * REFRESH_DIV + 1) begin
            @(negedge clk);
            if (dsel === 2'b10) seen_u = seg;
            else if (dsel === 2'b01) seen_t = seg;
        end
        check({tag, "_units"}, 32'(seen_u), 32'(seg_ref(value % 10)));
        check({tag, "_tens"}, 32'(seen_t),
              (value / 10 == 0) ? 32'h7F : 32'(seg_ref(value / 10)));
    endtask

    task automatic convert(input string tag, input int value);
        int len;
        @(negedge clk);
        score = 6'(value);
        run_conversion(len);
        check({tag, "_busy_len"}, len, 7);
        check_display(tag, value);
    endtask

    task automatic game_over_pulse(input string tag);
        @(negedge clk);
        lost_n = 1'b0;
`ifdef SC_SCOREDISPLAY_HISCORE_EN
        if (int'(score) > hi_model) hi_model = int'(score);
`endif
        repeat (3) @(negedge clk);
        check({tag, "_hiscore"}, 32'(hi), hi_model);
        lost_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int len, len2, last, v, f, run;
        bit busy_seen;
        logic [6:0] seen_u, seen_t;

        rst    = 1'b1;
        score  = 6'd0;
        lost_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h40);
        check("rst_dsel", 32'(dsel), 32'd2);
        check("rst_busy", 32'(busy), 0);
        check("rst_hi", 32'(hi), 0);
        rst = 1'b0;

        busy_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        check("idle_no_busy", 32'(busy_seen), 0);

        convert("s37", 37);
        convert("s05", 5);

        // 10 then 11 two cycles after busy rises
        @(negedge clk);
        score = 6'd10;
        len = 0;
        while (busy !== 1'b1 && len < 4) begin
            @(negedge clk);
            len++;
        end
        len = (busy === 1'b1) ? 1 : 0;
        repeat (2) begin
            @(negedge clk);
            if (busy === 1'b1) len++;
        end
        score = 6'd11;
        while (busy === 1'b1 && len < 30) begin
            @(negedge clk);
            if (busy === 1'b1) len++;
        end
        check("s10_busy_len", len, 7);
        seen_u = 'x;
        seen_t = 'x;
        len2 = 0;
        for (int i = 0; i < 2 * REFRESH_DIV; i++) begin
            @(negedge clk);
            if (busy === 1'b1) len2++;
            if (dsel === 2'b10) seen_u = seg;
            else if (dsel === 2'b01) seen_t = seg;
        end
        check("s10_units", 32'(seen_u), 32'(seg_ref(0)));
        check("s10_tens", 32'(seen_t), 32'(seg_ref(1)));
        check("s11_busy_len", len2, 7);
        check_display("s11", 11);

        last = 11;
        for (int k = 0; k < 8; k++) begin
            v = int'($urandom_range(0, 63));
            if (v == last) v = (v + 1) % 64;
            convert("rnd", v);
            last = v;
        end

        convert("s20", 20);
        game_over_pulse("go20");

        convert("s42", 42);
        @(negedge clk);
        lost_n = 1'b0;
`ifdef SC_SCOREDISPLAY_HISCORE_EN
        if (42 > hi_model) hi_model = 42;
`endif
        for (int i = 0; i < OBS; i++) begin
            @(negedge clk);
            dark[i] = (dsel === 2'b11);
            if (i == 3) check("go42_hiscore", 32'(hi), hi_model);
        end
        f = -1;
        for (int i = 0; i < OBS; i++) if (dark[i] && f < 0) f = i;
        check("blink_start", 32'((f >= 4) && (f <= 7)), 1);
        if (f < 0) f = 0;
        run = 0;
        while (f < OBS && dark[f]) begin run++; f++; end
        check("blink_dark_run", run, 2 * REFRESH_DIV);
        run = 0;
        while (f < OBS && !dark[f]) begin run++; f++; end
        check("blink_lit_run", run, 2 * REFRESH_DIV);
        run = 0;
        while (f < OBS && dark[f]) begin run++; f++; end
        check("blink_dark_run2", run, 2 * REFRESH_DIV);
        lost_n = 1'b1;
        repeat (2 * REFRESH_DIV + 1) @(negedge clk);
        check("go_release_dsel", 32'(dsel !== 2'b11), 1);

        convert("s30", 30);
        game_over_pulse("go30");

        // Reset three cycles into a conversion of 63
        @(negedge clk);
        score = 6'd63;
        len = 0;
        while (busy !== 1'b1 && len < 4) begin
            @(negedge clk);
            len++;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        hi_model = 0;
        #1;
        check("mid_rst_seg", 32'(seg), 32'h40);
        check("mid_rst_dsel", 32'(dsel), 32'd2);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_hi", 32'(hi), hi_model);
        @(negedge clk);
        rst = 1'b0;
        run_conversion(len);
        check("s63_busy_len", len, 7);
        check_display("s63", 63);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
